// File: rtl/core_trace_monitor_if.sv
// Trace stream bundle between the monitor (master) and a trace consumer (slave).
interface core_trace_monitor_if #(
  parameter int XLEN      = 32,
  parameter int NUM_WATCH = 3
);
  logic                                 trace_valid;
  logic                                 trace_ready;
  logic [32+XLEN+NUM_WATCH*XLEN-1:0]    trace_data;

  modport master (output trace_valid, output trace_data, input trace_ready);
  modport slave  (input trace_valid, input trace_data, output trace_ready);
endinterface

// File: rtl/core_trace_monitor.sv
// Retire-trace capture: records {cycle, pc, watched regs} into a FWFT FIFO during a
// bounded session that stops on a PC breakpoint or a cycle budget.
module core_trace_monitor #(
  parameter int XLEN       = 32,
  parameter int NUM_WATCH  = 3,
  parameter int DEPTH      = 16,
  parameter int MAX_CYCLES = 50
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      retire_valid,
  input  logic [XLEN-1:0]           pc_in,
  input  logic [NUM_WATCH*XLEN-1:0] watch_in,
  input  logic                      bp_en,
  input  logic [XLEN-1:0]           bp_addr,
  core_trace_monitor_if.master      trace,
  output logic [1:0]                state,
  output logic                      done,
  output logic                      bp_hit,
  output logic [15:0]               drop_count
);

  localparam int AW    = $clog2(DEPTH);
  localparam int REC_W = 32 + XLEN + NUM_WATCH * XLEN;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [31:0] LAST_CYCLE = 32'(MAX_CYCLES - 1);
  localparam logic [AW:0] PTR_ONE    = (AW+1)'(1);

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic [31:0]      cycle_r;
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic [15:0]      drop_r;
  logic             bp_hit_r;
  logic [REC_W-1:0] mem_r [DEPTH];

  logic             empty_s;
  logic             full_s;
  logic             pop_s;
  logic             run_s;
  logic             take_s;
  logic             push_s;
  logic             drop_s;
  logic             bp_match_s;
  logic             budget_s;
  logic             restart_s;
  logic [REC_W-1:0] record_s;

  // FIFO status, push/drop decision and next-state selection
  always_comb begin
    empty_s    = (wr_ptr_r == rd_ptr_r);
    full_s     = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    pop_s      = !empty_s && trace.trace_ready;
    run_s      = (state_r == ST_RUN);
    take_s     = run_s && retire_valid;
    // a full FIFO still takes the record when the head leaves on the same edge
    push_s     = take_s && (!full_s || pop_s);
    drop_s     = take_s && full_s && !pop_s;
    bp_match_s = take_s && bp_en && (pc_in == bp_addr);
    budget_s   = run_s && (cycle_r == LAST_CYCLE);
    restart_s  = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    record_s   = {cycle_r, pc_in, watch_in};
    case (state_r)
      ST_IDLE:  state_nxt_s = restart_s ? ST_RUN : ST_IDLE;
      ST_RUN:   state_nxt_s = (bp_match_s || budget_s) ? ST_DRAIN : ST_RUN;
      ST_DRAIN: state_nxt_s = empty_s ? ST_DONE : ST_DRAIN;
      ST_DONE:  state_nxt_s = restart_s ? ST_RUN : ST_DONE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // Session control, cycle counter, FIFO pointers and status flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      cycle_r  <= 32'd0;
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
      drop_r   <= 16'd0;
      bp_hit_r <= 1'b0;
    end else if (restart_s) begin
      state_r  <= state_nxt_s;
      cycle_r  <= 32'd0;
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
      drop_r   <= 16'd0;
      bp_hit_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (run_s) begin
        cycle_r <= cycle_r + 32'd1;
      end
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      if (drop_s && (drop_r != 16'hFFFF)) begin
        drop_r <= drop_r + 16'd1;
      end
      if (bp_match_s) begin
        bp_hit_r <= 1'b1;
      end
    end
  end

  // Record storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= record_s;
    end
  end

  assign trace.trace_valid = !empty_s;
  assign trace.trace_data  = empty_s ? {REC_W{1'b0}} : mem_r[rd_ptr_r[AW-1:0]];
  assign state             = state_r;
  assign done              = (state_r == ST_DONE);
  assign bp_hit            = bp_hit_r;
  assign drop_count        = drop_r;

endmodule

// File: tb/tb_core_trace_monitor.sv
// Randomized scoreboard bench: a queue-based session model predicts records, drops and
// state; a negedge monitor pops expected records whenever the consumer accepts one.
module tb_core_trace_monitor;

  localparam int DEPTH = 16;
  localparam int MAXC  = 50;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         rv;
  logic [31:0]  pc;
  logic         be;
  logic [31:0]  ba;
  logic         rdy;
  logic [95:0]  w3;
  logic [31:0]  w1;
  logic [255:0] w8;

  logic [1:0]  st3, st1, st8;
  logic        dn3, dn1, dn8, bp3, bp1, bp8;
  logic [15:0] dc3, dc1, dc8;

  core_trace_monitor_if #(.XLEN(32), .NUM_WATCH(3)) if3 ();
  core_trace_monitor_if #(.XLEN(32), .NUM_WATCH(1)) if1 ();
  core_trace_monitor_if #(.XLEN(32), .NUM_WATCH(8)) if8 ();
  assign if3.trace_ready = rdy;
  assign if1.trace_ready = rdy;
  assign if8.trace_ready = rdy;

  core_trace_monitor #(.XLEN(32), .NUM_WATCH(3), .DEPTH(DEPTH), .MAX_CYCLES(MAXC)) u_dut (
    .clk(clk), .reset(reset), .start(start), .retire_valid(rv), .pc_in(pc), .watch_in(w3),
    .bp_en(be), .bp_addr(ba), .trace(if3), .state(st3), .done(dn3), .bp_hit(bp3), .drop_count(dc3));
  core_trace_monitor #(.XLEN(32), .NUM_WATCH(1), .DEPTH(DEPTH), .MAX_CYCLES(MAXC)) u_w1 (
    .clk(clk), .reset(reset), .start(start), .retire_valid(rv), .pc_in(pc), .watch_in(w1),
    .bp_en(be), .bp_addr(ba), .trace(if1), .state(st1), .done(dn1), .bp_hit(bp1), .drop_count(dc1));
  core_trace_monitor #(.XLEN(32), .NUM_WATCH(8), .DEPTH(DEPTH), .MAX_CYCLES(MAXC)) u_w8 (
    .clk(clk), .reset(reset), .start(start), .retire_valid(rv), .pc_in(pc), .watch_in(w8),
    .bp_en(be), .bp_addr(ba), .trace(if8), .state(st8), .done(dn8), .bp_hit(bp8), .drop_count(dc8));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]  cyc;
    logic [31:0]  pc;
    logic [95:0]  w3;
    logic [31:0]  w1;
    logic [255:0] w8;
  } rec_t;

  rec_t sb[$];
  rec_t mon_e;

  int n_tests = 0;
  int n_fail  = 0;

  // session model: occupancy, counters and phase flags
  int          occ = 0;
  int          m_cyc = 0;
  int          m_drops = 0;
  bit          m_run = 0, m_drain = 0, m_fin = 0, m_bp = 0;
  logic [1:0]  exp_state = 2'd0;
  int          sess_pops = 0;
  logic [31:0] last_cyc, last_pc;

  task automatic check(input bit ok, input string nm, input logic [319:0] act, input logic [319:0] exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_clear();
    sb.delete();
    occ = 0; m_cyc = 0; m_drops = 0;
    m_run = 0; m_drain = 0; m_fin = 0; m_bp = 0;
    exp_state = 2'd0;
  endtask

  // monitor: valid prediction and record comparison at the accepting edge
  always @(negedge clk) begin
    if (!reset) begin
      check(if3.trace_valid === (occ > 0), "valid_nw3", 320'(if3.trace_valid), 320'(occ > 0));
      check(if1.trace_valid === (occ > 0), "valid_nw1", 320'(if1.trace_valid), 320'(occ > 0));
      check(if8.trace_valid === (occ > 0), "valid_nw8", 320'(if8.trace_valid), 320'(occ > 0));
      if (if3.trace_valid && rdy) begin
        if (sb.size() == 0) begin
          check(1'b0, "unexpected_record", 320'(if3.trace_data), 320'd0);
        end else begin
          mon_e = sb.pop_front();
          check(if3.trace_data === {mon_e.cyc, mon_e.pc, mon_e.w3}, "rec_nw3",
                320'(if3.trace_data), 320'({mon_e.cyc, mon_e.pc, mon_e.w3}));
          check(if1.trace_data === {mon_e.cyc, mon_e.pc, mon_e.w1}, "rec_nw1",
                320'(if1.trace_data), 320'({mon_e.cyc, mon_e.pc, mon_e.w1}));
          check(if8.trace_data === {mon_e.cyc, mon_e.pc, mon_e.w8}, "rec_nw8",
                if8.trace_data, {mon_e.cyc, mon_e.pc, mon_e.w8});
          last_cyc = if3.trace_data[159:128];
          last_pc  = if3.trace_data[127:96];
          sess_pops++;
        end
      end
    end
  end

  task automatic rand_watch();
    w3 = {$urandom, $urandom, $urandom};
    w1 = $urandom;
    for (int i = 0; i < 8; i++) w8[i*32 +: 32] = $urandom;
  endtask

  // mode: 0 basic, 1 overflow, 2 breakpoint, 3 random, 4 full-with-pop; abort_at>=0 returns mid-RUN
  task automatic session(input int mode, input int abort_at);
    bit s_be;
    logic [31:0] s_ba;
    int hold;
    bit pop;
    bit match;
    rec_t r;
    hold = 0;
    s_be = 1'($urandom_range(0, 1));
    s_ba = 32'($urandom_range(0, 15)) << 2;
    @(posedge clk); #1;
    check(st3 === exp_state, "state_pre_start", 320'(st3), 320'(exp_state));
    start = 1'b1; rv = 1'b0; rdy = 1'b1; be = 1'b0;
    @(negedge clk); #1;
    sb.delete();
    occ = 0; m_cyc = 0; m_drops = 0; m_bp = 0;
    m_run = 1; m_drain = 0; m_fin = 0; exp_state = 2'd1;
    sess_pops = 0;
    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      check(st3 === exp_state, "state", 320'(st3), 320'(exp_state));
      if (exp_state == 2'd3) break;
      if (abort_at >= 0 && m_run && m_cyc == abort_at) return;
      rand_watch();
      case (mode)
        1: begin
          rv = 1'b1; pc = $urandom; be = 1'b0;
          rdy = !(m_run || (m_drain && hold < 10));
          if (m_drain) hold++;
        end
        2: begin rv = 1'b1; pc = 32'(m_cyc) * 32'd4; be = 1'b1; ba = 32'h0000_0020; rdy = 1'b1; end
        3: begin
          rv = 1'($urandom_range(0, 1)); pc = 32'($urandom_range(0, 15)) << 2;
          be = s_be; ba = s_ba; rdy = ($urandom_range(0, 3) != 0);
        end
        4: begin rv = 1'b1; pc = $urandom; be = 1'b0; rdy = !(m_run && m_cyc < 18); end
        default: begin rv = 1'b1; pc = $urandom; be = 1'b0; rdy = 1'b1; end
      endcase
      @(negedge clk); #1;
      pop = (occ > 0) && rdy;
      if (m_run) begin
        if (rv) begin
          if (occ < DEPTH || pop) begin
            r.cyc = 32'(m_cyc); r.pc = pc; r.w3 = w3; r.w1 = w1; r.w8 = w8;
            sb.push_back(r);
            occ++;
          end else if (m_drops < 16'hFFFF) begin
            m_drops++;
          end
        end
        match = be && rv && (pc == ba);
        if (match) m_bp = 1;
        if (match || m_cyc == MAXC - 1) begin m_run = 0; m_drain = 1; end
        m_cyc++;
      end else if (m_drain && occ == 0) begin
        m_drain = 0; m_fin = 1;
      end
      if (pop) occ--;
      exp_state = m_run ? 2'd1 : (m_drain ? 2'd2 : (m_fin ? 2'd3 : 2'd0));
    end
    check(exp_state == 2'd3, "session_timeout", 320'(st3), 320'd3);
    check(dn3 === 1'b1, "done", 320'(dn3), 320'd1);
    check(bp3 === m_bp, "bp_hit", 320'(bp3), 320'(m_bp));
    check(dc3 === 16'(m_drops), "drop_count", 320'(dc3), 320'(m_drops));
    check(if3.trace_valid === 1'b0, "empty_at_done", 320'(if3.trace_valid), 320'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check(st3 === 2'd0 && dn3 === 1'b0, {tag, "_state"}, 320'({st3, dn3}), 320'd0);
    check(if3.trace_valid === 1'b0, {tag, "_valid"}, 320'(if3.trace_valid), 320'd0);
    check(bp3 === 1'b0 && dc3 === 16'd0, {tag, "_flags"}, 320'({bp3, dc3}), 320'd0);
    check(if3.trace_data === 160'd0, {tag, "_data"}, 320'(if3.trace_data), 320'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; rv = 1'b0; pc = 32'd0; be = 1'b0; ba = 32'd0; rdy = 1'b0;
    w3 = 96'd0; w1 = 32'd0; w8 = 256'd0;
    #3;
    check_reset_values("reset");
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    session(0, -1);
    check(sess_pops == 50, "basic_count", 320'(sess_pops), 320'd50);
    session(1, -1);
    check(sess_pops == 16, "ovf_count", 320'(sess_pops), 320'd16);
    check(dc3 === 16'd34, "ovf_drops", 320'(dc3), 320'd34);
    session(2, -1);
    check(last_cyc === 32'd8 && last_pc === 32'h20, "bp_last", 320'({last_cyc, last_pc}), 320'({32'd8, 32'h20}));
    check(bp3 === 1'b1, "bp_sticky", 320'(bp3), 320'd1);
    session(4, -1);
    check(dc3 === 16'd2, "full_pop_drops", 320'(dc3), 320'd2);
    for (int s = 0; s < 4; s++) session(3, -1);

    session(1, 20);
    #2 reset = 1'b1;
    #1 check_reset_values("async_reset");
    model_clear();
    @(posedge clk); #1;
    reset = 1'b0;
    session(0, -1);
    check(sess_pops == 50, "restart_count", 320'(sess_pops), 320'd50);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
